// File: rtl/mitchell_pkg.sv
// Shared types and constants for the Mitchell log-domain multiplier.
// The LOD/log-adder front end and the antilog back end both import this package.
package mitchell_pkg;

  localparam int FRAC_W = 7;
  localparam int K_W    = 4;
  localparam int OUT_W  = 16;
  localparam int EXP_W  = K_W + 1;

  typedef logic [FRAC_W:0] mant_t;
  typedef logic [EXP_W-1:0] exp_t;

  // Summed log-domain word; f carries the fraction-sum carry in its MSB.
  typedef struct packed {
    logic [K_W-1:0] k;
    logic [FRAC_W:0] f;
    logic            zero;
  } log_word_t;

endpackage

// File: rtl/antilog_shift.sv
// Combinational antilog barrel shift: p = (m << e) >> FRAC_W, saturating when
// the exponent exceeds the K_W-bit range.
module antilog_shift
  import mitchell_pkg::*;
(
  input  mant_t             m_i,
  input  exp_t              e_i,
  output logic [OUT_W-1:0]  p_o,
  output logic              sat_o
);

  // Wide enough for m shifted by the largest non-saturating exponent.
  localparam int SHIFT_W = FRAC_W + 1 + OUT_W;

  logic [SHIFT_W-1:0] wide;

  function automatic logic [OUT_W-1:0] saturate(input logic [SHIFT_W-1:0] x,
                                                 input logic ovf);
    return ovf ? {OUT_W{1'b1}} : x[FRAC_W +: OUT_W];
  endfunction

  assign sat_o = e_i[K_W];
  assign wide  = {{OUT_W{1'b0}}, m_i} << e_i[K_W-1:0];
  assign p_o   = saturate(wide, sat_o);

endmodule

// File: rtl/mitchell_antilog.sv
// Two-stage antilog decoder with valid/ready stall control on both sides.
// Stage 1 captures exponent/mantissa, stage 2 shifts and applies zero/saturation.
module mitchell_antilog
  import mitchell_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K_W-1:0]    in_k,
  input  logic [FRAC_W:0]   in_f,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_p,
  output logic              out_sat
);

  log_word_t        in_w;
  logic             adv1, adv2;
  logic             vld_p1_q, vld_p1_d;
  exp_t             e_p1_q, e_p1_d;
  mant_t            m_p1_q, m_p1_d;
  logic             zero_p1_q, zero_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic [OUT_W-1:0] p_p2_q, p_p2_d;
  logic             sat_p2_q, sat_p2_d;
  logic [OUT_W-1:0] shift_p;
  logic             shift_sat;

  assign in_w = '{k: in_k, f: in_f, zero: in_zero};

  assign adv2     = !vld_p2_q || out_ready;
  assign adv1     = !vld_p1_q || adv2;
  assign in_ready = adv1 || rst;

  antilog_shift u_shift (
    .m_i   (m_p1_q),
    .e_i   (e_p1_q),
    .p_o   (shift_p),
    .sat_o (shift_sat)
  );

  always_comb begin
    vld_p1_d  = vld_p1_q;
    e_p1_d    = e_p1_q;
    m_p1_d    = m_p1_q;
    zero_p1_d = zero_p1_q;
    vld_p2_d  = vld_p2_q;
    p_p2_d    = p_p2_q;
    sat_p2_d  = sat_p2_q;
    // Stage 1: re-insert the implicit one and fold the fraction carry into e.
    if (adv1) begin
      vld_p1_d  = in_valid;
      e_p1_d    = {1'b0, in_w.k} + {{K_W{1'b0}}, in_w.f[FRAC_W]};
      m_p1_d    = {1'b1, in_w.f[FRAC_W-1:0]};
      zero_p1_d = in_w.zero;
    end
    // Stage 2: shifted product, with a zero operand overriding saturation.
    if (adv2) begin
      vld_p2_d = vld_p1_q;
      p_p2_d   = zero_p1_q ? '0 : shift_p;
      sat_p2_d = !zero_p1_q && shift_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      p_p2_q   <= '0;
      sat_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      p_p2_q   <= p_p2_d;
      sat_p2_q <= sat_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    e_p1_q    <= e_p1_d;
    m_p1_q    <= m_p1_d;
    zero_p1_q <= zero_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_p     = p_p2_q;
  assign out_sat   = sat_p2_q;

endmodule
